decade_timer_ctrl: RTL

Sequencing controller for a cascaded chain of BCD decade counters (0–9 digits with carry-in/carry-out). It turns start/stop/clear commands into the chain's control strobes: load, clear, direction and a prescaled count-enable into the least-significant digit. It watches the chain's digit outputs to detect the terminal value and stop counting. It sits between the board push-button/switch logic and the counter chain, forming a count-down timer or a count-up stopwatch.

---
 rtl/decade_timer_ctrl_if.sv | 40 ++++
 rtl/decade_timer_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/decade_timer_ctrl_if.sv
// Control/status bundle between the board command logic, the timer
// controller and the cascaded BCD counter chain.
interface decade_timer_ctrl_if #(
  parameter int N_DIGITS = 4
);
  // Commands from the push-button/switch side.
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  mode_up;
  logic [4*N_DIGITS-1:0] preset;

  // Live value fed back from the counter chain.
  logic [4*N_DIGITS-1:0] digits;

  // Strobes and status driven by the controller.
  logic                  cnt_en;
  logic                  cnt_up;
  logic                  cnt_load;
  logic [4*N_DIGITS-1:0] cnt_load_val;
  logic                  cnt_clr;
  logic                  running;
  logic                  done;
  logic                  err;
  logic [2:0]            state;

  // Environment side: issues commands, presents the chain value.
  modport master (
    output start, stop, clear, mode_up, preset, digits,
    input  cnt_en, cnt_up, cnt_load, cnt_load_val, cnt_clr,
           running, done, err, state
  );

  // Controller side.
  modport slave (
    input  start, stop, clear, mode_up, preset, digits,
    output cnt_en, cnt_up, cnt_load, cnt_load_val, cnt_clr,
           running, done, err, state
  );
endinterface

// File: rtl/decade_timer_ctrl.sv
// Sequencing controller for a cascaded BCD decade counter chain: turns
// start/stop/clear commands into load/clear/direction strobes and a
// prescaled count-enable, and stops on the terminal value.
module decade_timer_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                reset,
  decade_timer_ctrl_if.slave  bus
);

  localparam int W  = 4 * N_DIGITS;
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic          start_prev;
  logic          stop_prev;
  logic          clear_prev;
  logic          start_edge;
  logic          stop_edge;
  logic          clear_edge;

  logic [W-1:0]  target_reg;
  logic          dir_reg;
  logic [PW-1:0] prescaler;

  logic          preset_ok;
  logic          terminal;
  logic          start_ready;
  logic          start_accept;
  logic          run_go;
  logic          load_strobe;

  // Command edge detectors; history flops clear on reset so a level already
  // high at reset release still yields an edge in the first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      clear_prev <= 1'b0;
    end else begin
      start_prev <= bus.start;
      stop_prev  <= bus.stop;
      clear_prev <= bus.clear;
    end
  end

  // Edges are qualified by reset so no combinational strobe can leak out
  // while the block is held in reset.
  always_comb begin
    start_edge = reset & bus.start & ~start_prev;
    stop_edge  = reset & bus.stop  & ~stop_prev;
    clear_edge = reset & bus.clear & ~clear_prev;
  end

  // A preset is usable only if every nibble is a legal BCD digit.
  always_comb begin
    preset_ok = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (bus.preset[4*i +: 4] > 4'd9) preset_ok = 1'b0;
    end
  end

  // Terminal value and event qualification for the current cycle.
  always_comb begin
    terminal     = dir_reg ? (bus.digits == target_reg) : (bus.digits == '0);
    start_ready  = (state_q == IDLE) || (state_q == DONE);
    start_accept = start_ready && start_edge && !clear_edge && preset_ok;
    // Prescaler only advances in RUN when no higher-priority event claims
    // the cycle (clear > terminal > stop > start > tick).
    run_go       = (state_q == RUN) && !clear_edge && !terminal && !stop_edge;
    load_strobe  = (state_q == LOAD) && !dir_reg && !clear_edge;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear_edge) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_edge && preset_ok) state_d = LOAD;
        LOAD:       state_d = ARM;
        ARM:        state_d = RUN;
        RUN: begin
          if (terminal)       state_d = DONE;
          else if (stop_edge) state_d = PAUSE;
        end
        PAUSE: begin
          // Stop outranks start, so a coincident pair keeps us paused.
          if (stop_edge)       state_d = PAUSE;
          else if (start_edge) state_d = RUN;
        end
        default:    state_d = IDLE;
      endcase
    end
  end

  // Target and direction are captured only on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_reg <= '0;
      dir_reg    <= 1'b1;
    end else if (start_accept) begin
      target_reg <= bus.preset;
      dir_reg    <= bus.mode_up;
    end
  end

  // Prescaler: zeroed in ARM, counts in RUN, frozen everywhere else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (state_q == ARM) begin
      prescaler <= '0;
    end else if (run_go) begin
      prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
    end
  end

  // Output decode.
  always_comb begin
    bus.cnt_en       = run_go && (prescaler == PS_LAST);
    bus.cnt_up       = dir_reg;
    bus.cnt_load     = load_strobe;
    bus.cnt_load_val = load_strobe ? target_reg : '0;
    bus.cnt_clr      = clear_edge || ((state_q == LOAD) && dir_reg);
    bus.running      = (state_q == RUN);
    bus.done         = (state_q == DONE);
    bus.err          = start_ready && start_edge && !clear_edge && !preset_ok;
    bus.state        = state_q;
  end

endmodule
